// File: rtl/trig_phase_sequencer.sv
// rtl/trig_phase_sequencer.sv - multi-octave phase counter bank driving sin/cos table addresses
//
// Purpose: for each accepted sample of one octave, emits one {bin, pos} table
// address per beat for every bin of that octave, then advances that bin's phase
// modulo its runtime-programmable wave length.
//
// Optional feature macro: TRIG_QUAD_ADDR_EN (adds addr_cos_pos, a quarter-wave
// shifted address so a single sin table can also serve cosine).
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   samp_valid/ready    sample request stream, samp_octave selects the octave
//   cfg_we/bin/len      per-bin wave length write (len 0 means 2**N), IDLE only
//   clr                 synchronous clear of all phases, FSM back to IDLE
//   addr_valid/ready    address beat stream
//   addr_bin/octave/pos beat payload, addr_last marks bin BINS-1
//   addr_cos_pos        (TRIG_QUAD_ADDR_EN only) pos + L/4 wrapped to L
module trig_phase_sequencer #(
    parameter int N       = 6,
    parameter int BINS    = 24,
    parameter int OCTAVES = 5
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   samp_valid,
    output logic                                   samp_ready,
    input  logic [((OCTAVES > 1) ? $clog2(OCTAVES) : 1)-1:0] samp_octave,
    input  logic                                   cfg_we,
    input  logic [$clog2(BINS)-1:0]                cfg_bin,
    input  logic [N-1:0]                           cfg_len,
    input  logic                                   clr,
    output logic                                   addr_valid,
    input  logic                                   addr_ready,
    output logic [$clog2(BINS)-1:0]                addr_bin,
    output logic [((OCTAVES > 1) ? $clog2(OCTAVES) : 1)-1:0] addr_octave,
    output logic [N-1:0]                           addr_pos,
`ifdef TRIG_QUAD_ADDR_EN
    output logic [N-1:0]                           addr_cos_pos,
`endif
    output logic                                   addr_last
);

    localparam int BW = $clog2(BINS);
    localparam int OW = (OCTAVES > 1) ? $clog2(OCTAVES) : 1;
    localparam int PW = $clog2(OCTAVES * BINS);
    localparam logic [N:0] FULL_L = {1'b1, {N{1'b0}}};

    typedef enum logic {IDLE, SCAN} state_t;

    state_t          state_q;
    logic [N-1:0]    phase_q [OCTAVES*BINS];
    logic [N-1:0]    len_q   [BINS];
    logic            samp_ready_q, addr_valid_q, addr_last_q;
    logic [BW-1:0]   addr_bin_q;
    logic [OW-1:0]   addr_octave_q;
    logic [N-1:0]    addr_pos_q;

    function automatic logic [N:0] eff_len(input logic [N-1:0] len);
        return (len == '0) ? FULL_L : {1'b0, len};
    endfunction

    function automatic logic [PW-1:0] idx(input logic [OW-1:0] o, input logic [BW-1:0] b);
        return PW'(o) * PW'(BINS) + PW'(b);
    endfunction

    // Phase of the current beat is addr_pos_q itself: nothing else writes that
    // bin's register while it is on the output.
    logic            samp_ok, cfg_ok, is_last_bin;
    logic [BW-1:0]   bin_nxt;
    logic [OW-1:0]   samp_oct_safe;
    logic [N:0]      pos_inc, cur_len, first_len, nxt_len;
    logic [N-1:0]    pos_adv, first_pos, nxt_pos;

    always_comb begin
        samp_ok       = samp_valid && (int'(samp_octave) < OCTAVES);
        cfg_ok        = cfg_we && (int'(cfg_bin) < BINS);
        is_last_bin   = (addr_bin_q == BW'(BINS - 1));
        // Out-of-range indices are steered to 0 so reads never leave the arrays.
        bin_nxt       = is_last_bin ? '0 : addr_bin_q + 1'b1;
        samp_oct_safe = samp_ok ? samp_octave : '0;
        cur_len       = eff_len(len_q[addr_bin_q]);
        pos_inc       = {1'b0, addr_pos_q} + 1'b1;
        pos_adv       = (pos_inc >= cur_len) ? '0 : pos_inc[N-1:0];
        first_pos     = phase_q[idx(samp_oct_safe, '0)];
        // A same-cycle write to bin 0 must already apply to the first beat.
        first_len     = (cfg_ok && cfg_bin == '0) ? eff_len(cfg_len) : eff_len(len_q[0]);
        nxt_pos       = phase_q[idx(addr_octave_q, bin_nxt)];
        nxt_len       = eff_len(len_q[bin_nxt]);
    end

`ifdef TRIG_QUAD_ADDR_EN
    logic [N-1:0] addr_cos_pos_q;

    function automatic logic [N-1:0] cos_of(input logic [N-1:0] pos, input logic [N:0] l);
        logic [N:0] sum;
        logic [N:0] wrapped;
        sum     = {1'b0, pos} + (l >> 2);
        wrapped = (sum >= l) ? sum - l : sum;
        return wrapped[N-1:0];
    endfunction

    assign addr_cos_pos = addr_cos_pos_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < OCTAVES * BINS; i++) phase_q[i] <= '0;
            for (int i = 0; i < BINS; i++) len_q[i] <= '0;
            state_q       <= IDLE;
            samp_ready_q  <= 1'b1;
            addr_valid_q  <= 1'b0;
            addr_bin_q    <= '0;
            addr_octave_q <= '0;
            addr_pos_q    <= '0;
            addr_last_q   <= 1'b0;
`ifdef TRIG_QUAD_ADDR_EN
            addr_cos_pos_q <= '0;
`endif
        end else if (clr) begin
            for (int i = 0; i < OCTAVES * BINS; i++) phase_q[i] <= '0;
            state_q      <= IDLE;
            samp_ready_q <= 1'b1;
            addr_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_ok) len_q[cfg_bin] <= cfg_len;
                    if (samp_ok) begin
                        state_q       <= SCAN;
                        samp_ready_q  <= 1'b0;
                        addr_valid_q  <= 1'b1;
                        addr_octave_q <= samp_octave;
                        addr_bin_q    <= '0;
                        addr_pos_q    <= first_pos;
                        addr_last_q   <= (BINS == 1);
`ifdef TRIG_QUAD_ADDR_EN
                        addr_cos_pos_q <= cos_of(first_pos, first_len);
`endif
                    end
                end
                SCAN: begin
                    if (addr_ready) begin
                        phase_q[idx(addr_octave_q, addr_bin_q)] <= pos_adv;
                        if (is_last_bin) begin
                            state_q      <= IDLE;
                            samp_ready_q <= 1'b1;
                            addr_valid_q <= 1'b0;
                            addr_last_q  <= 1'b0;
                        end else begin
                            addr_bin_q  <= bin_nxt;
                            addr_pos_q  <= nxt_pos;
                            addr_last_q <= (bin_nxt == BW'(BINS - 1));
`ifdef TRIG_QUAD_ADDR_EN
                            addr_cos_pos_q <= cos_of(nxt_pos, nxt_len);
`endif
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign samp_ready  = samp_ready_q;
    assign addr_valid  = addr_valid_q;
    assign addr_bin    = addr_bin_q;
    assign addr_octave = addr_octave_q;
    assign addr_pos    = addr_pos_q;
    assign addr_last   = addr_last_q;

    logic unused_ok;
    assign unused_ok = ^{nxt_len, first_len};

endmodule

// File: tb/tb_trig_phase_sequencer.sv
// tb/tb_trig_phase_sequencer.sv - directed self-checking bench for trig_phase_sequencer
module tb_trig_phase_sequencer;

    localparam int N = 6, BINS = 24, OCTAVES = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       samp_valid = 1'b0, samp_ready;
    logic [2:0] samp_octave = '0;
    logic       cfg_we = 1'b0;
    logic [4:0] cfg_bin = '0;
    logic [5:0] cfg_len = '0;
    logic       clr = 1'b0;
    logic       addr_valid, addr_ready = 1'b1, addr_last;
    logic [4:0] addr_bin;
    logic [2:0] addr_octave;
    logic [5:0] addr_pos;
`ifdef TRIG_QUAD_ADDR_EN
    logic [5:0] addr_cos_pos;
`endif

    int tests = 0;
    int fails = 0;
    int got_pos [BINS];
    int got_cos [BINS];

    always #5 clk = ~clk;

    trig_phase_sequencer #(.N(N), .BINS(BINS), .OCTAVES(OCTAVES)) dut (
        .clk(clk), .rst(rst),
        .samp_valid(samp_valid), .samp_ready(samp_ready), .samp_octave(samp_octave),
        .cfg_we(cfg_we), .cfg_bin(cfg_bin), .cfg_len(cfg_len), .clr(clr),
        .addr_valid(addr_valid), .addr_ready(addr_ready), .addr_bin(addr_bin),
        .addr_octave(addr_octave), .addr_pos(addr_pos),
`ifdef TRIG_QUAD_ADDR_EN
        .addr_cos_pos(addr_cos_pos),
`endif
        .addr_last(addr_last)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic cfg_write(input int bin, input int len);
        @(negedge clk);
        cfg_we = 1'b1; cfg_bin = 5'(bin); cfg_len = 6'(len);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // One sample request and its scan; beat payloads go to got_pos/got_cos.
    // stall_bin: drop addr_ready for 3 cycles there. abort_bin: clr (or async
    // rst when use_rst) while that beat is on the output.
    task automatic run_sample(input int oct, input int stall_bin, input int abort_bin,
                              input bit use_rst, input bit scan_cfg);
        @(negedge clk);
        check("samp_ready_idle", samp_ready, 1);
        samp_valid = 1'b1; samp_octave = 3'(oct);
        @(negedge clk);
        samp_valid = 1'b0;
        if (scan_cfg) begin
            cfg_we = 1'b1; cfg_bin = 5'd0; cfg_len = 6'd2;
        end
        check("first_beat_valid", addr_valid, 1);
        for (int b = 0; b < BINS; b++) begin
            check("beat_valid", addr_valid, 1);
            check("beat_bin", addr_bin, b);
            check("beat_octave", addr_octave, oct);
            check("beat_last", addr_last, (b == BINS - 1) ? 1 : 0);
            got_pos[b] = int'(addr_pos);
`ifdef TRIG_QUAD_ADDR_EN
            got_cos[b] = int'(addr_cos_pos);
`endif
            if (b == abort_bin) begin
                if (use_rst) begin
                    #2 rst = 1'b0;
                    #1;
                    check("async_rst_valid", addr_valid, 0);
                    check("async_rst_ready", samp_ready, 1);
                    check("async_rst_bin", addr_bin, 0);
                    check("async_rst_pos", addr_pos, 0);
                    @(negedge clk);
                    rst = 1'b1;
                end else begin
                    clr = 1'b1;
                    @(negedge clk);
                    clr = 1'b0;
                    check("clr_valid", addr_valid, 0);
                    check("clr_ready", samp_ready, 1);
                end
                cfg_we = 1'b0;
                return;
            end
            if (b == stall_bin) begin
                addr_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_valid", addr_valid, 1);
                    check("stall_bin", addr_bin, b);
                    check("stall_pos", addr_pos, got_pos[b]);
                end
                addr_ready = 1'b1;
            end
            @(negedge clk);
        end
        cfg_we = 1'b0;
        check("scan_end_valid", addr_valid, 0);
        check("scan_end_ready", samp_ready, 1);
    endtask

    initial begin
        for (int i = 0; i < BINS; i++) begin got_pos[i] = 0; got_cos[i] = 0; end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_samp_ready", samp_ready, 1);
        check("rst_addr_valid", addr_valid, 0);
        check("rst_addr_bin", addr_bin, 0);
        check("rst_addr_octave", addr_octave, 0);
        check("rst_addr_pos", addr_pos, 0);
        check("rst_addr_last", addr_last, 0);
        rst = 1'b1;

        // First sample: all bins at phase 0
        run_sample(0, -1, -1, 0, 0);
        for (int b = 0; b < BINS; b++) check("first_scan_pos", got_pos[b], 0);

        // Short wave on bin 3; cfg write held during the first scan is ignored
        reset_dut();
        cfg_write(3, 5);
        @(negedge clk);
        samp_valid = 1'b1; samp_octave = 3'd5;
        @(negedge clk);
        samp_valid = 1'b0;
        check("bad_octave_valid", addr_valid, 0);
        check("bad_octave_ready", samp_ready, 1);
        for (int k = 0; k < 6; k++) begin
            run_sample(0, -1, -1, 0, k == 0);
            check("len5_bin3_pos", got_pos[3], k % 5);
            check("len64_bin0_pos", got_pos[0], k);
`ifdef TRIG_QUAD_ADDR_EN
            check("len5_bin3_cos", got_cos[3], ((k % 5) + 1) % 5);
            check("len64_bin0_cos", got_cos[0], (k + 16) % 64);
`endif
        end

        // Full 2**N wave wraps after 64 samples
        reset_dut();
        for (int k = 0; k < 65; k++) begin
            run_sample(1, -1, -1, 0, 0);
            check("full_wave_pos", got_pos[0], k % 64);
`ifdef TRIG_QUAD_ADDR_EN
            check("full_wave_cos", got_cos[0], (k + 16) % 64);
`endif
        end

        // Backpressure at bin 7
        reset_dut();
        run_sample(0, -1, -1, 0, 0);
        run_sample(0, -1, -1, 0, 0);
        run_sample(0, 7, -1, 0, 0);
        check("stall_scan_bin7", got_pos[7], 2);
        run_sample(0, -1, -1, 0, 0);
        check("after_stall_bin7", got_pos[7], 3);
        check("after_stall_bin8", got_pos[8], 3);

        // Octave independence
        reset_dut();
        repeat (3) run_sample(2, -1, -1, 0, 0);
        run_sample(0, -1, -1, 0, 0);
        for (int b = 0; b < BINS; b++) check("oct0_untouched", got_pos[b], 0);
        run_sample(2, -1, -1, 0, 0);
        for (int b = 0; b < BINS; b++) check("oct2_advanced", got_pos[b], 3);

        // clr mid-scan: phases cleared, lengths kept; clr blocks a same-cycle request
        reset_dut();
        cfg_write(3, 5);
        run_sample(0, -1, -1, 0, 0);
        run_sample(0, -1, -1, 0, 0);
        run_sample(0, -1, 10, 0, 0);
        @(negedge clk);
        clr = 1'b1; samp_valid = 1'b1; samp_octave = 3'd0;
        @(negedge clk);
        clr = 1'b0; samp_valid = 1'b0;
        check("clr_samp_valid", addr_valid, 0);
        check("clr_samp_ready", samp_ready, 1);
        for (int k = 0; k < 6; k++) begin
            run_sample(0, -1, -1, 0, 0);
            check("post_clr_bin3", got_pos[3], k % 5);
            check("post_clr_bin11", got_pos[11], k);
        end

        // Async reset mid-scan: phases and lengths back to defaults
        run_sample(0, -1, 10, 1, 0);
        for (int k = 0; k < 6; k++) begin
            run_sample(0, -1, -1, 0, 0);
            check("post_rst_bin3", got_pos[3], k);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
